edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel rising-edge event collector and scheduler. Each of N level inputs feeds a Moore rising-edge detector. Detected edges are latched as pending events and presented one at a time on a valid/ready output. A round-robin arbiter chooses among pending channels. The block sits between asynchronous-ish status levels (already synchronised upstream) and a single event consumer such as an interrupt or logging unit.

## Interface
- N, 4, number of channels, legal range 2..16
- IDW, $clog2(N), width of the channel index
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- level  in  N  per-channel level inputs, sampled on clk
- evt_valid  out  1  an event is presented
- evt_id  out  IDW  channel index of the presented event
- evt_ready  in  1  consumer accepts the event when high with evt_valid
- overrun  out  N  sticky per-channel flag: an edge was lost
- clr_overrun  in  1  clears all overrun bits

## Operation
- Per-channel detector is a Moore FSM with states ZERO, EDGE and ONE.
  - ZERO goes to EDGE when level=1; otherwise it stays in ZERO.
  - EDGE goes to ONE when level=1, or to ZERO when level=0.
  - ONE goes to ZERO when level=0; otherwise it stays in ONE.
  - tick[i]=1 only in EDGE, so it is exactly one cycle per rising edge.
- A pending[i] bit is set by tick[i] and cleared when channel i is loaded into the output register.
- Output register (evt_valid, evt_id):
  - It may load when it is empty, or when evt_valid & evt_ready in this cycle.
  - On load, if any pending bit is set, it takes the winner; otherwise evt_valid←0.
- Round-robin selection:
  - The search starts at ptr and wraps N-1→0.
  - After a grant of channel g, ptr←(g+1) mod N.
  - ptr does not change when nothing is granted.
- Simultaneous events on one channel:
  - tick[i] while pending[i]=1 and channel i is not loaded this cycle: pending[i] stays 1 and overrun[i]←1.
  - tick[i] in the same cycle channel i is loaded: pending[i] stays 1 and there is no overrun.
- clr_overrun clears all overrun bits. A new overrun in the same cycle wins, so that bit reads 1.
- While evt_valid=1 and evt_ready=0, evt_id is held stable. evt_valid never drops without a handshake.

## Timing
- Reset values:
  - All detectors are in ZERO.
  - pending=0 and ptr=0.
  - evt_valid=0 and evt_id=0.
  - overrun=0.
- Reset mid-operation discards all pending and presented events.
- A level held high across reset produces one edge after reset is released.
- Latency with the output idle:
  - Level is sampled high at edge k.
  - tick is high in cycle k→k+1.
  - pending is set at edge k+1.
  - evt_valid=1 after edge k+2.
- Throughput is one event per cycle while evt_ready is held high.
- A channel can re-detect no sooner than every 2 cycles: a level pattern 1,0,1 gives an edge on each rise.

## Structure
- Package edge_arb_pkg holds:
  - the detector state type, encoded ZERO=2'b00, EDGE=2'b01, ONE=2'b10;
  - the default N.
- Sub-module rise_detector (clk, reset, level, tick) is the single-channel Moore FSM, instantiated N times by a generate loop.
- The arbiter, pending bits and output register live in the top module.

## Test plan
- Reset, then level[2] 0→1 at cycle 3 with evt_ready=1 -> evt_valid=1 with evt_id=2 for exactly one cycle, starting 2 cycles after the sampling edge; no overrun.
- level=4'b1111 rising together, evt_ready=1, ptr=0 -> evt_id=0,1,2,3 on consecutive cycles, then evt_valid=0.
- level[1] rises with evt_ready=0, then rises again after a fall -> evt_id=1 held stable, overrun[1]=1. After ready, exactly one event for channel 1 is delivered.
- overrun[1] set and clr_overrun pulsed in the same cycle as a new overrun on channel 1 -> overrun[1] stays 1. With clr_overrun alone -> overrun=0.
- Grant channel 3 with channels 0 and 3 re-pending -> next grant is 0 (wrap), then 3.
- Assert reset while evt_valid=1 and pending=4'b0110 -> all outputs are 0 the next cycle. With level held high through reset, one event per high channel follows release.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge event arbiter.
package edge_arb_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    EDGE = 2'b01,
    ONE  = 2'b10
  } det_state_e;

endpackage

// File: rtl/rise_detector.sv
// Single-channel Moore rising-edge detector; tick is high for exactly one
// cycle per rising edge of level.
module rise_detector
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ZERO;
    tick    = 1'b0;
    case (state_q)
      ZERO: state_d = level ? EDGE : ZERO;
      EDGE: begin
        tick    = 1'b1;
        state_d = level ? ONE : ZERO;
      end
      ONE:  state_d = level ? ONE : ZERO;
      default: state_d = ZERO;
    endcase
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects per-channel rising edges as pending events and presents them one
// at a time on a valid/ready port, chosen round-robin.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   overrun,
  input  logic           clr_overrun
);

  logic [N-1:0]   tick;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           evt_valid_q, evt_valid_d;
  logic [IDW-1:0] evt_id_q, evt_id_d;

  logic           load_en;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [N-1:0]   upper_mask;
  logic [N-1:0]   load_mask;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      rise_detector u_det (
        .clk   (clk),
        .reset (reset),
        .level (level[gi]),
        .tick  (tick[gi])
      );
      // Channels at or above ptr get first claim; the rest are the wrap-around.
      assign upper_mask[gi] = (IDW'(gi) >= ptr_q);
      assign load_mask[gi]  = load_en & grant_found & (grant_idx == IDW'(gi));
    end
  endgenerate

  assign load_en = ~evt_valid_q | evt_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_found && pending_q[i] && upper_mask[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_found && pending_q[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      evt_valid_d = grant_found;
      if (grant_found) begin
        evt_id_d = grant_idx;
        ptr_d    = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
    // A fresh edge re-arms pending even if the same channel is loaded now.
    pending_d = (pending_q & ~load_mask) | tick;
    overrun_d = (clr_overrun ? '0 : overrun_q) | (tick & pending_q & ~load_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expectations.
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] overrun;
  logic       clr_overrun;

  int checks;
  int errors;

  edge_event_arbiter #(.N(4), .IDW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .level       (level),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    level       = 4'b0000;
    evt_ready   = 1'b1;
    clr_overrun = 1'b0;
    reset       = 1'b1;
    cyc(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Single edge on channel 2: valid two cycles after the sampling edge, one cycle long.
    level = 4'b0100;
    cyc(1);
    chk("t1_lat1_valid", 32'(evt_valid), 32'd0);
    cyc(1);
    chk("t1_lat2_valid", 32'(evt_valid), 32'd0);
    cyc(1);
    chk("t1_valid", 32'(evt_valid), 32'd1);
    chk("t1_id", 32'(evt_id), 32'd2);
    level = 4'b0000;
    cyc(1);
    chk("t1_drop", 32'(evt_valid), 32'd0);
    chk("t1_overrun", 32'(overrun), 32'd0);
    cyc(1);

    // All four rise together from ptr=0: ids 0..3 back to back.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    level = 4'b1111;
    cyc(1);
    chk("t2_early_valid", 32'(evt_valid), 32'd0);
    cyc(2);
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", 32'(evt_valid), 32'd1);
      chk("t2_id", 32'(evt_id), 32'(k));
      cyc(1);
    end
    chk("t2_end_valid", 32'(evt_valid), 32'd0);
    level = 4'b0000;
    cyc(2);

    // Channel 1 pulses 1,0,1,0,1 while the consumer stalls.
    evt_ready = 1'b0;
    level = 4'b0010; cyc(1);
    level = 4'b0000; cyc(1);
    level = 4'b0010; cyc(1);
    chk("t3_first_valid", 32'(evt_valid), 32'd1);
    chk("t3_first_id", 32'(evt_id), 32'd1);
    level = 4'b0000; cyc(1);
    level = 4'b0010; cyc(1);
    chk("t3_no_overrun_yet", 32'(overrun), 32'd0);
    cyc(1);
    chk("t3_overrun", 32'(overrun), 32'b0010);
    chk("t3_held_valid", 32'(evt_valid), 32'd1);
    chk("t3_held_id", 32'(evt_id), 32'd1);
    level = 4'b0000;
    evt_ready = 1'b1;
    cyc(1);
    chk("t3_second_valid", 32'(evt_valid), 32'd1);
    chk("t3_second_id", 32'(evt_id), 32'd1);
    cyc(1);
    chk("t3_drained", 32'(evt_valid), 32'd0);

    // New overrun on channel 1 in the same cycle as clr_overrun.
    evt_ready = 1'b0;
    level = 4'b0010; cyc(1);
    level = 4'b0000; cyc(1);
    level = 4'b0010; cyc(1);
    level = 4'b0000; cyc(1);
    level = 4'b0010; cyc(1);
    clr_overrun = 1'b1;
    cyc(1);
    chk("t4_set_wins", 32'(overrun), 32'b0010);
    cyc(1);
    chk("t4_clear", 32'(overrun), 32'd0);
    clr_overrun = 1'b0;
    level = 4'b0000;
    evt_ready = 1'b1;
    cyc(1);
    chk("t4_pend_valid", 32'(evt_valid), 32'd1);
    chk("t4_pend_id", 32'(evt_id), 32'd1);
    cyc(1);
    chk("t4_drained", 32'(evt_valid), 32'd0);

    // Grant channel 3, then channels 0 and 3 pending: order wraps to 0 then 3.
    evt_ready = 1'b0;
    level = 4'b1000; cyc(1);
    level = 4'b0000; cyc(1);
    level = 4'b1001; cyc(1);
    chk("t5_g3_valid", 32'(evt_valid), 32'd1);
    chk("t5_g3_id", 32'(evt_id), 32'd3);
    cyc(1);
    chk("t5_hold_id", 32'(evt_id), 32'd3);
    evt_ready = 1'b1;
    cyc(1);
    chk("t5_wrap_id", 32'(evt_id), 32'd0);
    cyc(1);
    chk("t5_next_valid", 32'(evt_valid), 32'd1);
    chk("t5_next_id", 32'(evt_id), 32'd3);
    cyc(1);
    chk("t5_done", 32'(evt_valid), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);

    // Reset while channel 3 is presented and 1,2 pending; levels held high.
    level = 4'b0000;
    evt_ready = 1'b0;
    cyc(2);
    level = 4'b1000; cyc(1);
    level = 4'b1110; cyc(2);
    chk("t6_pre_valid", 32'(evt_valid), 32'd1);
    chk("t6_pre_id", 32'(evt_id), 32'd3);
    reset = 1'b1;
    cyc(1);
    chk("t6_rst_valid", 32'(evt_valid), 32'd0);
    chk("t6_rst_id", 32'(evt_id), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    evt_ready = 1'b1;
    cyc(1);
    chk("t6_post1_valid", 32'(evt_valid), 32'd0);
    cyc(1);
    chk("t6_post2_valid", 32'(evt_valid), 32'd0);
    for (int k = 1; k < 4; k++) begin
      cyc(1);
      chk("t6_ev_valid", 32'(evt_valid), 32'd1);
      chk("t6_ev_id", 32'(evt_id), 32'(k));
    end
    cyc(1);
    chk("t6_end_valid", 32'(evt_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
